// File: rtl/ts_chk8.sv
// Receive-side checker for the 8-bit parallel MPEG-TS test interface.
// Delineates 188-byte packets, checks sync/len/PID/CC/payload and keeps statistics.
module ts_chk8 #(
   parameter int          U_DLY       = 1,
   parameter logic [12:0] EXP_PID     = 13'h0014,
   parameter bit          CHK_PAYLOAD = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ts_sync,
   input  logic        ts_valid,
   input  logic        ts_eop,
   input  logic [7:0]  ts_data,
   output logic        pkt_done,
   output logic        pkt_err,
   output logic [4:0]  err_flags,
   output logic        cc_lock,
   output logic [31:0] pkt_cnt,
   output logic [15:0] err_cnt
);

   if (U_DLY < 0) begin : g_bad_udly
      $error("U_DLY must be non-negative");
   end

   localparam int E_SYNC = 0;
   localparam int E_LEN  = 1;
   localparam int E_PID  = 2;
   localparam int E_CC   = 3;
   localparam int E_DATA = 4;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [4:0]  flags_q, flags_d;
   logic [4:0]  pid_hi_q, pid_hi_d;
   logic        pid_ok_q, pid_ok_d;
   logic        chk_pay_q, chk_pay_d;
   logic [3:0]  cc_q, cc_d;
   logic        cc_lock_q, cc_lock_d;
   logic        term_q, term_d;
   logic [4:0]  term_flags_q, term_flags_d;
   logic        pkt_done_q, pkt_done_d;
   logic        pkt_err_q, pkt_err_d;
   logic [4:0]  err_flags_q, err_flags_d;
   logic [31:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   logic        in_pkt;
   logic [7:0]  idx_nxt;
   logic [4:0]  byte_err;
   logic [4:0]  len_err;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      flags_d      = flags_q;
      pid_hi_d     = pid_hi_q;
      pid_ok_d     = pid_ok_q;
      chk_pay_d    = chk_pay_q;
      cc_d         = cc_q;
      cc_lock_d    = cc_lock_q;
      term_d       = 1'b0;
      term_flags_d = term_flags_q;
      byte_err     = 5'd0;
      len_err      = 5'd0;
      idx_nxt      = idx_q + 8'd1;
      in_pkt       = (state_q == S_HDR) || (state_q == S_PAYLOAD);

      if (state_q == S_DONE) state_d = S_IDLE;

      if (ts_valid) begin
         if (ts_sync) begin
            // A sync always opens a new packet; any open packet is cut short.
            if (in_pkt) begin
               term_d       = 1'b1;
               term_flags_d = flags_q | (5'd1 << E_LEN);
            end
            state_d   = S_HDR;
            idx_d     = 8'd1;
            flags_d   = (ts_data != 8'h47) ? (5'd1 << E_SYNC) : 5'd0;
            pid_ok_d  = 1'b0;
            chk_pay_d = 1'b0;
         end else if (in_pkt) begin
            if (idx_q == 8'd188) begin
               term_d       = 1'b1;
               term_flags_d = flags_q | (5'd1 << E_LEN);
               state_d      = S_DONE;
            end else begin
               idx_d = idx_nxt;
               case (idx_nxt)
                  8'd2: pid_hi_d = ts_data[4:0];
                  8'd3: begin
                     if ({pid_hi_q, ts_data} != EXP_PID) byte_err[E_PID] = 1'b1;
                     else                                 pid_ok_d = 1'b1;
                  end
                  8'd4: begin
                     state_d   = S_PAYLOAD;
                     chk_pay_d = (ts_data[5:4] == 2'b01);
                     // CC tracked only on the expected PID with a payload present.
                     if (pid_ok_q && ts_data[4]) begin
                        cc_d      = ts_data[3:0];
                        cc_lock_d = 1'b1;
                        if (cc_lock_q && (ts_data[3:0] != cc_q + 4'd1)) byte_err[E_CC] = 1'b1;
                     end
                  end
                  default: begin
                     if (CHK_PAYLOAD && chk_pay_q && (ts_data != idx_nxt - 8'd4))
                        byte_err[E_DATA] = 1'b1;
                  end
               endcase
               flags_d = flags_q | byte_err;
               if (ts_eop) begin
                  if (idx_nxt != 8'd188) len_err[E_LEN] = 1'b1;
                  term_d       = 1'b1;
                  term_flags_d = flags_q | byte_err | len_err;
                  state_d      = S_DONE;
               end
            end
         end
      end
   end

   // Verdict stage runs one cycle behind the parser so a new packet can start meanwhile.
   always_comb begin
      pkt_done_d  = term_q;
      pkt_err_d   = pkt_err_q;
      err_flags_d = err_flags_q;
      pkt_cnt_d   = pkt_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (term_q) begin
         err_flags_d = term_flags_q;
         pkt_err_d   = |term_flags_q;
         pkt_cnt_d   = pkt_cnt_q + 32'd1;
         if ((|term_flags_q) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= 8'd0;
         flags_q      <= 5'd0;
         pid_hi_q     <= 5'd0;
         pid_ok_q     <= 1'b0;
         chk_pay_q    <= 1'b0;
         cc_q         <= 4'd0;
         cc_lock_q    <= 1'b0;
         term_q       <= 1'b0;
         term_flags_q <= 5'd0;
         pkt_done_q   <= 1'b0;
         pkt_err_q    <= 1'b0;
         err_flags_q  <= 5'd0;
         pkt_cnt_q    <= 32'd0;
         err_cnt_q    <= 16'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         flags_q      <= flags_d;
         pid_hi_q     <= pid_hi_d;
         pid_ok_q     <= pid_ok_d;
         chk_pay_q    <= chk_pay_d;
         cc_q         <= cc_d;
         cc_lock_q    <= cc_lock_d;
         term_q       <= term_d;
         term_flags_q <= term_flags_d;
         pkt_done_q   <= pkt_done_d;
         pkt_err_q    <= pkt_err_d;
         err_flags_q  <= err_flags_d;
         pkt_cnt_q    <= pkt_cnt_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign pkt_done  = pkt_done_q;
   assign pkt_err   = pkt_err_q;
   assign err_flags = err_flags_q;
   assign cc_lock   = cc_lock_q;
   assign pkt_cnt   = pkt_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ts_chk8.sv
// Bench for ts_chk8: packet-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ts_chk8;

   localparam logic [12:0] EXP_PID = 13'h0014;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ts_sync = 1'b0;
   logic        ts_valid = 1'b0;
   logic        ts_eop = 1'b0;
   logic [7:0]  ts_data = 8'd0;
   logic        pkt_done;
   logic        pkt_err;
   logic [4:0]  err_flags;
   logic        cc_lock;
   logic [31:0] pkt_cnt;
   logic [15:0] err_cnt;

   ts_chk8 #(.U_DLY(1), .EXP_PID(EXP_PID), .CHK_PAYLOAD(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .ts_sync(ts_sync), .ts_valid(ts_valid),
      .ts_eop(ts_eop), .ts_data(ts_data), .pkt_done(pkt_done), .pkt_err(pkt_err),
      .err_flags(err_flags), .cc_lock(cc_lock), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int eop_cyc = 0;
   int done_cyc = 0;
   logic [4:0] hist[$];

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model: whole-packet evaluation ----------------
   logic [7:0]  mb[$];
   bit          m_in = 0;
   bit          m_lock = 0;
   logic [3:0]  m_cc = 4'd0;
   bit          m_ccerr = 0;
   bit          m_pend = 0;
   logic [4:0]  m_pflags = 5'd0;
   logic        e_done = 0, e_err = 0;
   logic [4:0]  e_flags = 5'd0;
   logic [31:0] e_pcnt = 32'd0;
   logic [15:0] e_ecnt = 16'd0;

   function automatic logic [4:0] verdict(input bit len);
      logic [4:0] f;
      f = 5'd0;
      if (mb[0] != 8'h47) f[0] = 1'b1;
      if (len) f[1] = 1'b1;
      if (mb.size() >= 3 && {mb[1][4:0], mb[2]} != EXP_PID) f[2] = 1'b1;
      if (m_ccerr) f[3] = 1'b1;
      if (mb.size() >= 4 && mb[3][5:4] == 2'b01)
         for (int i = 4; i < mb.size(); i++)
            if (mb[i] != 8'(i - 3)) f[4] = 1'b1;
      return f;
   endfunction

   task automatic m_close(input bit len);
      m_pend   = 1;
      m_pflags = verdict(len);
   endtask

   task automatic m_cc_step();
      logic [3:0] c;
      c = mb[3][3:0];
      if ({mb[1][4:0], mb[2]} == EXP_PID && mb[3][4]) begin
         if (m_lock) m_ccerr = (c != 4'((m_cc + 1) % 16));
         m_lock = 1;
         m_cc   = c;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mb.delete(); m_in = 0; m_lock = 0; m_cc = 0; m_ccerr = 0; m_pend = 0;
         e_done = 0; e_err = 0; e_flags = 0; e_pcnt = 0; e_ecnt = 0;
      end else begin
         e_done = m_pend;
         if (m_pend) begin
            e_flags = m_pflags;
            e_err   = |m_pflags;
            e_pcnt  = e_pcnt + 1;
            if (|m_pflags && e_ecnt != 16'hFFFF) e_ecnt = e_ecnt + 1;
         end
         m_pend = 0;
         if (ts_valid) begin
            if (ts_sync) begin
               if (m_in) m_close(1);
               mb.delete();
               mb.push_back(ts_data);
               m_in = 1;
               m_ccerr = 0;
            end else if (m_in) begin
               if (mb.size() == 188) begin
                  m_close(1);
                  m_in = 0;
               end else begin
                  mb.push_back(ts_data);
                  if (mb.size() == 4) m_cc_step();
                  if (ts_eop) begin
                     m_close(mb.size() != 188);
                     m_in = 0;
                  end
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      checks++;
      if ({pkt_done, pkt_err, err_flags, cc_lock, pkt_cnt, err_cnt} !==
          {e_done, e_err, e_flags, m_lock, e_pcnt, e_ecnt}) begin
         errors++;
         $display("FAIL cycle_compare @%0d: dut done=%0b err=%0b flags=%b lock=%0b pcnt=%0d ecnt=%0d, expected done=%0b err=%0b flags=%b lock=%0b pcnt=%0d ecnt=%0d",
                  cyc, pkt_done, pkt_err, err_flags, cc_lock, pkt_cnt, err_cnt,
                  e_done, e_err, e_flags, m_lock, e_pcnt, e_ecnt);
      end
      if (pkt_done === 1'b1) begin
         hist.push_back(err_flags);
         done_cyc = cyc;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] pkt[$];

   task automatic build(input logic [3:0] cc);
      pkt.delete();
      pkt.push_back(8'h47);
      pkt.push_back({3'b000, EXP_PID[12:8]});
      pkt.push_back(EXP_PID[7:0]);
      pkt.push_back({4'b0001, cc});
      for (int i = 1; i <= 184; i++) pkt.push_back(8'(i));
   endtask

   task automatic drive(input bit s, input bit e, input logic [7:0] d);
      @(negedge clk);
      ts_valid = 1'b1; ts_sync = s; ts_eop = e; ts_data = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         ts_valid = 1'b0; ts_sync = 1'b0; ts_eop = 1'b0; ts_data = 8'($urandom);
      end
   endtask

   task automatic send(input int n, input bit with_eop, input int gap_every, input int gap_len,
                       input bit eop_first);
      bit e;
      for (int i = 0; i < n; i++) begin
         if (gap_every > 0 && i > 0 && (i % gap_every) == 0) idle(gap_len);
         e = (with_eop && i == n - 1) || (eop_first && i == 0);
         drive(i == 0, e, pkt[i]);
         if (with_eop && i == n - 1) eop_cyc = cyc + 1;
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] acc;
      logic [7:0] tmp;
      logic [3:0] rcc;
      int r;

      idle(3);
      chk("reset_done", pkt_done, 0);
      chk("reset_flags", err_flags, 0);
      chk("reset_lock", cc_lock, 0);
      chk("reset_pcnt", pkt_cnt, 0);
      chk("reset_ecnt", err_cnt, 0);
      rst_n = 1'b1;

      // four clean back-to-back packets
      hist.delete();
      for (int c = 1; c <= 4; c++) begin
         build(4'(c));
         send(188, 1, 0, 0, 0);
         if (c == 1) chk("t1_lock_first", cc_lock, 1);
      end
      idle(3);
      acc = 0;
      foreach (hist[i]) acc |= hist[i];
      chk("t1_pulses", hist.size(), 4);
      chk("t1_flags", acc, 0);
      chk("t1_pcnt", pkt_cnt, 4);
      chk("t1_ecnt", err_cnt, 0);

      // bad sync byte, then bad payload byte
      hist.delete();
      build(5); pkt[0] = 8'h46; send(188, 1, 0, 0, 0);
      build(6); pkt[99] = 8'h00; send(188, 1, 0, 0, 0);
      idle(3);
      chk("t2_sync", hist[0], 5'b00001);
      chk("t2_data", hist[1], 5'b10000);
      chk("t2_ecnt", err_cnt, 2);

      // CC 5,6,8,9 from a fresh lock
      rst_n = 1'b0; idle(2); rst_n = 1'b1;
      hist.delete();
      build(5); send(188, 1, 0, 0, 0);
      build(6); send(188, 1, 0, 0, 0);
      build(8); send(188, 1, 0, 0, 0);
      build(9); send(188, 1, 0, 0, 0);
      idle(3);
      chk("t3_n", hist.size(), 4);
      chk("t3_p2", hist[1], 5'b00000);
      chk("t3_p3", hist[2], 5'b01000);
      chk("t3_p4", hist[3], 5'b00000);

      // short packet, sync-cut packet, then clean
      hist.delete();
      build(10); send(187, 1, 0, 0, 0);
      build(11); send(49, 0, 0, 0, 0);
      build(12); send(188, 1, 0, 0, 0);
      idle(3);
      chk("t4_short", hist[0], 5'b00010);
      chk("t4_cut", hist[1], 5'b00010);
      chk("t4_clean", hist[2], 5'b00000);

      // gapped packet: verdict exactly one cycle after eop
      hist.delete();
      build(13); send(188, 1, 10, 3, 0);
      idle(3);
      chk("t5_n", hist.size(), 1);
      chk("t5_flags", hist[0], 0);
      chk("t5_latency", done_cyc - eop_cyc, 1);

      // reset in mid-packet
      build(14); send(90, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_pcnt", pkt_cnt, 0);
      chk("t6_rst_lock", cc_lock, 0);
      chk("t6_rst_ecnt", err_cnt, 0);
      idle(2); rst_n = 1'b1;
      hist.delete();
      build(3); send(188, 1, 0, 0, 0);
      idle(3);
      chk("t6_pcnt", pkt_cnt, 1);
      chk("t6_lock", cc_lock, 1);
      chk("t6_flags", hist[0], 0);

      // randomized traffic
      rcc = 4'd4;
      for (int p = 0; p < 200; p++) begin
         rcc = ($urandom_range(0, 9) == 0) ? 4'($urandom) : rcc + 4'd1;
         build(rcc);
         r = $urandom_range(0, 19);
         case (r)
            0: pkt[0] = 8'($urandom);
            1: pkt[2] = 8'($urandom);
            2: begin tmp = pkt[3]; tmp[5:4] = 2'($urandom); pkt[3] = tmp; end
            3: begin
               tmp = 8'($urandom_range(1, 255));
               pkt[$urandom_range(4, 187)] ^= tmp;
            end
            default: ;
         endcase
         if (r == 4)      send($urandom_range(1, 187), 1, $urandom_range(0, 40), $urandom_range(1, 3), 0);
         else if (r == 5) send($urandom_range(1, 187), 0, 0, 0, 0);
         else if (r == 6) begin
            send(188, 0, 0, 0, 0);
            drive(0, $urandom_range(0, 1), 8'($urandom));
         end
         else if (r == 7) send(188, 1, 0, 0, 1);
         else if (r == 8) begin
            send(188, 1, 0, 0, 0);
            drive(0, 0, 8'($urandom));
            drive(0, 1, 8'($urandom));
         end
         else if (r == 9 && p % 4 == 0) begin
            send($urandom_range(5, 150), 0, 0, 0, 0);
            #2 rst_n = 1'b0;
            idle(1); rst_n = 1'b1;
         end
         else send(188, 1, $urandom_range(0, 1) ? $urandom_range(1, 60) : 0, $urandom_range(1, 4), 0);
         if ($urandom_range(0, 1)) idle($urandom_range(1, 3));
      end
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ts_chk8.md
# ts_chk8

Receive-side checker for the 8-bit parallel MPEG-TS test interface (ts_sync / ts_valid / ts_eop / ts_data). It sits at the far end of a TS link in test benches and on-board loopback paths. It delineates 188-byte packets and checks the sync byte, length, PID, continuity counter and the incrementing payload pattern. It then reports a per-packet verdict plus running statistics.

## Interface
- U_DLY, 1, register update delay (simulation only)
- EXP_PID, 13'h0014, PID every packet must carry
- CHK_PAYLOAD, 1, 1 = check the payload pattern, 0 = skip the payload check
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ts_sync  input  1  marks the first byte of a packet; qualified by ts_valid
- ts_valid  input  1  byte strobe; may deassert mid-packet (gaps allowed)
- ts_eop  input  1  marks the last byte of a packet; qualified by ts_valid
- ts_data  input  8  packet byte
- pkt_done  output  1  one-cycle pulse: a packet verdict is available
- pkt_err  output  1  verdict with pkt_done: 1 = at least one err_flags bit set
- err_flags  output  5  held from one pkt_done to the next; bit 0 = SYNC, 1 = LEN, 2 = PID, 3 = CC, 4 = DATA
- cc_lock  output  1  a reference CC value has been captured
- pkt_cnt  output  32  packets completed (good + bad), wraps
- err_cnt  output  16  packets with pkt_err = 1, saturates at 16'hFFFF

## Operation
- Byte position idx (1..188) advances only on ts_valid. A byte with ts_valid = 1 and ts_sync = 1 always forces idx = 1.
- FSM states:
  - IDLE: bytes without sync are discarded.
  - HDR: idx 1–4.
  - PAYLOAD: idx 5–188.
  - DONE: single cycle; issues the verdict, then returns to IDLE.
- IDLE → HDR on a valid sync byte.
- SYNC error: the byte at idx 1 ≠ 8'h47.
- PID: {byte2[4:0], byte3} ≠ EXP_PID → PID error.
- AFC = byte4[5:4]; CC = byte4[3:0].
- Payload check applies when CHK_PAYLOAD = 1 and AFC = 2'b01.
  - Each byte at idx 5..188 must equal (idx − 4) mod 256, i.e. the sequence 1..184.
  - Any mismatch → DATA error.
- CC check (only when PID is correct and AFC[0] = 1):
  - If cc_lock = 0: capture CC, set cc_lock, flag no error.
  - Otherwise the expected value is (last CC + 1) mod 16; a mismatch, including a repeat, → CC error.
  - The stored CC always updates to the received value, so the checker resyncs after one error.
- LEN error, three cases:
  - ts_eop at idx ≠ 188: packet terminates.
  - Sync at idx 2..188: the current packet terminates with LEN, and the sync byte starts a new packet.
  - A valid non-sync byte after idx 188 without ts_eop: packet terminates, FSM → IDLE.
- When ts_eop and ts_sync occur on the same byte, the sync takes precedence: the old packet gets LEN, and the new packet starts with idx = 1. That byte's eop is ignored.
- The errors of one packet OR together into err_flags.

## Timing
- Reset values: pkt_done = 0, pkt_err = 0, err_flags = 0, cc_lock = 0, pkt_cnt = 0, err_cnt = 0, FSM = IDLE, stored CC = 0.
- pkt_done asserts exactly 1 cycle after the terminating byte's clock edge. In the same cycle, pkt_err, err_flags, pkt_cnt and err_cnt present updated values.
- Back-to-back packets with no gap must be accepted. The DONE verdict and the next packet's idx 1 are processed in the same cycle (verdict register separate from parse state).
- ts_valid = 0 cycles freeze idx and state; there is no timeout.
- A reset assertion mid-packet immediately returns everything to reset values. The partial packet is not counted.
- pkt_cnt wraps 32'hFFFFFFFF → 0; err_cnt holds at 16'hFFFF.

## Test plan
- Reset, then 4 back-to-back packets (PID 0x0014, AFC 01, CC 1, 2, 3, 4, payload 1..184) → 4 pkt_done pulses, pkt_err = 0, cc_lock = 1 after the first packet, pkt_cnt = 4, err_cnt = 0.
- Packet with byte 1 = 8'h46 and another with the payload byte at idx 100 = 8'h00 → err_flags = 5'b00001, then 5'b10000; err_cnt = 2.
- CC sequence 5, 6, 8, 9 → only the third packet reports CC (err_flags = 5'b01000); the fourth is clean.
- ts_eop at idx 187; then a new sync at idx 50 of the next packet → both packets LEN (5'b00010); the packet started at that sync completes clean.
- Valid gaps of 3 cycles every 10 bytes with a correct packet → pkt_done exactly 1 cycle after the eop byte, no error.
- Deassert rst_n at idx 90 → all outputs 0 immediately; the next full packet is counted as pkt_cnt = 1 and sets cc_lock without a CC error.
